lsu_mem_ctrl: RTL and testbench

Memory-stage load/store controller for the RISC-V pipeline. Sequences one data-memory access per memory-stage instruction over a req/ack bus and generates byte enables and lane-replicated write data. Aligns and sign/zero-extends load data per funct3. Stalls the pipeline until the access completes, with a bus timeout.

---
 rtl/lsu_mem_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// Memory-stage load/store controller: one req/ack bus access per instruction,
// byte enables, lane-replicated store data, load extraction, bus timeout.
// Optional misaligned-access trap: define LSU_MISALIGN_TRAP_EN.
//
// state | meaning
// IDLE  | waiting; StallM follows MemReqM, request captured on MemReqM
// REQ   | DMemReq asserted, waiting for DMemAck or timeout
// DONE  | one-cycle completion; status pulses, pipeline released
module lsu_mem_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    MemReqM,
  input  logic                    MemWriteM,
  input  logic [2:0]              LoadSrcM,
  input  logic [2:0]              StoreSrcM,
  input  logic [ADDR_WIDTH-1:0]   ALUResultM,
  input  logic [DATA_WIDTH-1:0]   WriteDataM,
  output logic                    StallM,
  output logic [DATA_WIDTH-1:0]   ReadPartDataM,
  output logic                    ReadValidM,
  output logic                    BusErrM,
  output logic                    MisalignM,
  output logic                    DMemReq,
  output logic                    DMemWe,
  output logic [ADDR_WIDTH-1:0]   DMemAddr,
  output logic [DATA_WIDTH-1:0]   DMemWData,
  output logic [DATA_WIDTH/8-1:0] DMemBe,
  input  logic                    DMemAck,
  input  logic [DATA_WIDTH-1:0]   DMemRData
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [ADDR_WIDTH-3:0]   addr_q, addr_d;
  logic                    we_q, we_d;
  logic [3:0]              be_q, be_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [2:0]              lsrc_q, lsrc_d;
  logic [1:0]              alo_q, alo_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    valid_q, valid_d;
  logic                    err_q, err_d;

  logic [1:0]  a;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;

  assign a = ALUResultM[1:0];

  always_comb begin
    be_new    = 4'b1111;
    wdata_new = WriteDataM;
    if (MemWriteM) begin
      case (StoreSrcM)
        3'b000: begin
          be_new    = 4'b0001 << a;
          wdata_new = {4{WriteDataM[7:0]}};
        end
        3'b001: begin
          be_new    = a[1] ? 4'b1100 : 4'b0011;
          wdata_new = {2{WriteDataM[15:0]}};
        end
        default: ;
      endcase
    end
  end

  function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] lo,
                                          input logic [31:0] d);
    logic [31:0] sh;
    logic [15:0] h;
    sh = d >> {lo, 3'b000};
    h  = lo[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  extract = {{24{sh[7]}}, sh[7:0]};
      3'b100:  extract = {24'b0, sh[7:0]};
      3'b001:  extract = {{16{h[15]}}, h};
      3'b101:  extract = {16'b0, h};
      default: extract = d;
    endcase
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis_q, mis_d;
  logic mis_new;
  logic [2:0] f3_sel;

  assign f3_sel = MemWriteM ? StoreSrcM : LoadSrcM;

  always_comb begin
    case (f3_sel)
      3'b000:  mis_new = MemWriteM ? 1'b0 : 1'b0;
      3'b100:  mis_new = MemWriteM ? (a != 2'b00) : 1'b0;
      3'b001:  mis_new = a[0];
      3'b101:  mis_new = MemWriteM ? (a != 2'b00) : a[0];
      default: mis_new = (a != 2'b00);
    endcase
  end

  assign MisalignM = (state_q == DONE) & mis_q;
`else
  assign MisalignM = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    lsrc_d  = lsrc_q;
    alo_d   = alo_q;
    rdata_d = rdata_q;
    valid_d = valid_q;
    err_d   = err_q;
`ifdef LSU_MISALIGN_TRAP_EN
    mis_d   = mis_q;
`endif
    case (state_q)
      IDLE: begin
        if (MemReqM) begin
          addr_d  = ALUResultM[ADDR_WIDTH-1:2];
          we_d    = MemWriteM;
          be_d    = be_new;
          wdata_d = wdata_new;
          lsrc_d  = LoadSrcM;
          alo_d   = a;
          cnt_d   = '0;
          valid_d = 1'b0;
          err_d   = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
          mis_d   = mis_new;
          state_d = mis_new ? DONE : REQ;
`else
          state_d = REQ;
`endif
        end
      end
      REQ: begin
        if (DMemAck) begin
          if (!we_q) begin
            rdata_d = extract(lsrc_q, alo_q, DMemRData);
            valid_d = 1'b1;
          end
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      lsrc_q  <= '0;
      alo_q   <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      lsrc_q  <= lsrc_d;
      alo_q   <= alo_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      err_q   <= err_d;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_q   <= mis_d;
`endif
    end
  end

  // Request is decoded from the state register so an async reset drops it at once.
  assign DMemReq       = (state_q == REQ);
  assign StallM        = (state_q == IDLE) ? MemReqM : (state_q == REQ);
  assign DMemWe        = we_q;
  assign DMemAddr      = {addr_q, 2'b00};
  assign DMemWData     = wdata_q;
  assign DMemBe        = be_q;
  assign ReadPartDataM = rdata_q;
  assign ReadValidM    = (state_q == DONE) & valid_q;
  assign BusErrM       = (state_q == DONE) & err_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed test-plan cases, then random
// accesses checked against an arithmetic reference model.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemReqM, MemWriteM;
  logic [2:0]  LoadSrcM, StoreSrcM;
  logic [31:0] ALUResultM, WriteDataM;
  logic        StallM;
  logic [31:0] ReadPartDataM;
  logic        ReadValidM, BusErrM, MisalignM;
  logic        DMemReq, DMemWe;
  logic [31:0] DMemAddr, DMemWData;
  logic [3:0]  DMemBe;
  logic        DMemAck;
  logic [31:0] DMemRData;

  int n_cmp = 0;
  int n_mis = 0;
  logic [31:0] exp_rd;

  always #5 clk = ~clk;

  lsu_mem_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .MemReqM(MemReqM), .MemWriteM(MemWriteM),
    .LoadSrcM(LoadSrcM), .StoreSrcM(StoreSrcM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .StallM(StallM), .ReadPartDataM(ReadPartDataM),
    .ReadValidM(ReadValidM), .BusErrM(BusErrM), .MisalignM(MisalignM),
    .DMemReq(DMemReq), .DMemWe(DMemWe), .DMemAddr(DMemAddr),
    .DMemWData(DMemWData), .DMemBe(DMemBe),
    .DMemAck(DMemAck), .DMemRData(DMemRData)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [3:0] ref_be(input logic we, input int f3, input int a);
    if (we && f3 == 0) return 4'(1 << a);
    if (we && f3 == 1) return (a >= 2) ? 4'd12 : 4'd3;
    return 4'd15;
  endfunction

  function automatic logic [31:0] ref_wdata(input int f3, input logic [31:0] w);
    if (f3 == 0) return (w & 32'hFF) * 32'h01010101;
    if (f3 == 1) return (w & 32'hFFFF) * 32'h00010001;
    return w;
  endfunction

  function automatic logic [31:0] ref_load(input int f3, input int a, input logic [31:0] d);
    logic [31:0] v;
    if (f3 == 0 || f3 == 4) begin
      v = (d >> (8 * a)) & 32'hFF;
      if (f3 == 0 && v >= 128) v = v + 32'hFFFFFF00;
    end else if (f3 == 1 || f3 == 5) begin
      v = (d >> (16 * (a / 2))) & 32'hFFFF;
      if (f3 == 1 && v >= 32768) v = v + 32'hFFFF0000;
    end else begin
      v = d;
    end
    return v;
  endfunction

  function automatic logic ref_mis(input logic we, input int f3, input int a);
`ifdef LSU_MISALIGN_TRAP_EN
    int size;
    if (we) size = (f3 == 0) ? 1 : (f3 == 1) ? 2 : 4;
    else    size = (f3 == 0 || f3 == 4) ? 1 : (f3 == 1 || f3 == 5) ? 2 : 4;
    return (a % size) != 0;
`else
    return 1'b0;
`endif
  endfunction

  // ack_at: REQ cycle (1-based) on which DMemAck is given; 0 = never (timeout).
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata, input int ack_at);
    int  a;
    logic mis, tmo;
    int  nreq;
    a    = int'(addr[1:0]);
    mis  = ref_mis(we, int'(f3), a);
    tmo  = !mis && (ack_at == 0 || ack_at > 16);
    nreq = tmo ? 16 : ack_at;
    @(negedge clk);
    MemReqM = 1'b1; MemWriteM = we; LoadSrcM = f3; StoreSrcM = f3;
    ALUResultM = addr; WriteDataM = wdata; DMemAck = 1'b0;
    #1;
    check("idle_stall", 32'(StallM), 32'd1);
    check("idle_req", 32'(DMemReq), 32'd0);
    if (!mis) begin
      for (int k = 1; k <= nreq; k++) begin
        @(negedge clk);
        #1;
        check("req_req", 32'(DMemReq), 32'd1);
        check("req_stall", 32'(StallM), 32'd1);
        if (k == 1) begin
          check("req_addr", DMemAddr, addr & 32'hFFFFFFFC);
          check("req_we", 32'(DMemWe), 32'(we));
          check("req_be", 32'(DMemBe), 32'(ref_be(we, int'(f3), a)));
          if (we) check("req_wdata", DMemWData, ref_wdata(int'(f3), wdata));
        end
        if (k == ack_at) begin
          DMemAck = 1'b1;
          DMemRData = rdata;
        end
      end
    end
    @(negedge clk);
    DMemAck = 1'b0;
    DMemRData = $urandom;
    #1;
    if (tmo) exp_rd = 32'd0;
    else if (!mis && !we) exp_rd = ref_load(int'(f3), a, rdata);
    check("done_stall", 32'(StallM), 32'd0);
    check("done_req", 32'(DMemReq), 32'd0);
    check("done_valid", 32'(ReadValidM), 32'(!mis && !tmo && !we));
    check("done_buserr", 32'(BusErrM), 32'(tmo));
    check("done_misalign", 32'(MisalignM), 32'(mis));
    check("done_rdata", ReadPartDataM, exp_rd);
    @(negedge clk);
    MemReqM = 1'b0;
    #1;
    check("post_req", 32'(DMemReq), 32'd0);
    check("post_stall", 32'(StallM), 32'd0);
    check("post_valid", 32'(ReadValidM), 32'd0);
    check("post_buserr", 32'(BusErrM), 32'd0);
    check("post_misalign", 32'(MisalignM), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n = 1'b0; MemReqM = 1'b0; MemWriteM = 1'b0; LoadSrcM = 3'd0; StoreSrcM = 3'd0;
    ALUResultM = '0; WriteDataM = '0; DMemAck = 1'b0; DMemRData = '0;
    exp_rd = 32'd0;
    #12;
    check("rst_req", 32'(DMemReq), 32'd0);
    check("rst_rdata", ReadPartDataM, 32'd0);
    check("rst_valid", 32'(ReadValidM), 32'd0);
    check("rst_be", 32'(DMemBe), 32'd0);
    check("rst_addr", DMemAddr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    access(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'h0, 2);
    access(1'b0, 3'b000, 32'h0000_2001, 32'h0, 32'h1234_80FF, 1);
    check("lb_value", ReadPartDataM, 32'hFFFF_FF80);
    access(1'b0, 3'b100, 32'h0000_2001, 32'h0, 32'h1234_80FF, 1);
    check("lbu_value", ReadPartDataM, 32'h0000_0080);
    access(1'b0, 3'b001, 32'h0000_2002, 32'h0, 32'h9ABC_0000, 1);
    check("lh_value", ReadPartDataM, 32'hFFFF_9ABC);
    access(1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'h9ABC_0000, 3);
    check("lhu_value", ReadPartDataM, 32'h0000_9ABC);
    access(1'b1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 32'h0, 1);
    check("sh_hold_rdata", ReadPartDataM, 32'h0000_9ABC);
    access(1'b0, 3'b010, 32'h0000_2000, 32'h0, 32'h0, 0);
    check("tmo_value", ReadPartDataM, 32'h0);
    access(1'b0, 3'b010, 32'h0000_2004, 32'h0, 32'hCAFE_F00D, 16);

    // Ack while idle must be ignored.
    @(negedge clk);
    DMemAck = 1'b1; DMemRData = 32'h1111_1111;
    @(negedge clk);
    DMemAck = 1'b0;
    #1;
    check("stray_ack_req", 32'(DMemReq), 32'd0);
    check("stray_ack_valid", 32'(ReadValidM), 32'd0);
    check("stray_ack_rdata", ReadPartDataM, exp_rd);

    // Reset during the third REQ cycle abandons the request.
    @(negedge clk);
    MemReqM = 1'b1; MemWriteM = 1'b0; LoadSrcM = 3'b010; ALUResultM = 32'h0000_4000;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("mid_req_before", 32'(DMemReq), 32'd1);
    rst_n = 1'b0;
    #1;
    exp_rd = 32'd0;
    check("mid_req_after", 32'(DMemReq), 32'd0);
    check("mid_rdata", ReadPartDataM, 32'd0);
    MemReqM = 1'b0;
    #1;
    check("mid_stall", 32'(StallM), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    access(1'b0, 3'b010, 32'h0000_4000, 32'h0, 32'hDEAD_BEEF, 2);
    check("mid_lw_value", ReadPartDataM, 32'hDEAD_BEEF);

    access(1'b0, 3'b010, 32'h0000_3002, 32'h0, 32'h5566_7788, 1);

    for (int i = 0; i < 40; i++) begin
      logic       we;
      logic [2:0] f3;
      int         ack;
      we  = 1'($urandom_range(0, 1));
      f3  = 3'($urandom_range(0, 7));
      ack = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 4));
      access(we, f3, $urandom, $urandom, $urandom, ack);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
